// File: rtl/vga_cmd_decoder.sv
// Byte-stream command decoder feeding vgamult: parses framed host commands into
// sprite position/attribute loads, background select and nibble-wide font writes.
module vga_cmd_decoder #(
  parameter int FONT_AW  = 11,
  parameter int SPRITE_W = 5
) (
  input  logic                clk_100,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [9:0]          x,
  output logic [8:0]          y,
  output logic [SPRITE_W-1:0] sprite_sel,
  output logic                visable,
  output logic                load_pos,
  output logic                load_att,
  output logic [1:0]          background_sel,
  output logic                bchange_active,
  output logic                fchange_active,
  output logic [FONT_AW-1:0]  fwaddr,
  output logic [3:0]          fwdata,
  output logic                fwenable,
  output logic                busy,
  output logic                err
);

  typedef enum logic [3:0] {
    IDLE, P1, P2, P3, ISSUE, F_AH, F_AL, F_CNT, F_DATA, F_WLO, F_WHI, F_END
  } state_t;

  typedef enum logic [1:0] {CMD_POS, CMD_ATT, CMD_BG} cmd_t;

  state_t               state_q, state_d;
  cmd_t                 cmd_q, cmd_d;
  logic [7:0]           b1_q, b1_d;
  logic [7:0]           xlo_q, xlo_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [3:0]           hi_q, hi_d;
  logic [FONT_AW-1:0]   addr_q, addr_d;
  logic                 in_ready_q, in_ready_d;
  logic [9:0]           x_q, x_d;
  logic [8:0]           y_q, y_d;
  logic [SPRITE_W-1:0]  sprite_q, sprite_d;
  logic                 vis_q, vis_d;
  logic                 load_pos_q, load_pos_d;
  logic                 load_att_q, load_att_d;
  logic [1:0]           bg_q, bg_d;
  logic                 bchg_q, bchg_d;
  logic                 fchg_q, fchg_d;
  logic [FONT_AW-1:0]   fwaddr_q, fwaddr_d;
  logic [3:0]           fwdata_q, fwdata_d;
  logic                 fwen_q, fwen_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 xfer;

  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    b1_d       = b1_q;
    xlo_d      = xlo_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    sprite_d   = sprite_q;
    vis_d      = vis_q;
    bg_d       = bg_q;
    fchg_d     = fchg_q;
    fwaddr_d   = fwaddr_q;
    fwdata_d   = fwdata_q;
    load_pos_d = 1'b0;
    load_att_d = 1'b0;
    bchg_d     = 1'b0;
    fwen_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: if (xfer) begin
        case (in_data[3:0])
          4'h1:    begin cmd_d = CMD_POS; state_d = P1; end
          4'h2:    begin cmd_d = CMD_ATT; state_d = P1; end
          4'h3:    begin cmd_d = CMD_BG;  state_d = P1; end
          4'h4:    state_d = F_AH;
          default: err_d = 1'b1;
        endcase
      end
      P1: if (xfer) begin
        case (cmd_q)
          CMD_POS: begin b1_d = in_data; state_d = P2; end
          CMD_ATT: begin
            sprite_d   = in_data[SPRITE_W-1:0];
            vis_d      = in_data[7];
            load_att_d = 1'b1;
            state_d    = ISSUE;
          end
          default: begin
            bg_d    = in_data[1:0];
            bchg_d  = 1'b1;
            state_d = ISSUE;
          end
        endcase
      end
      P2: if (xfer) begin xlo_d = in_data; state_d = P3; end
      // Position fields land together so vgamult never sees a half-updated sprite.
      P3: if (xfer) begin
        sprite_d   = b1_q[SPRITE_W-1:0];
        x_d        = {b1_q[6:5], xlo_q};
        y_d        = {b1_q[7], in_data};
        load_pos_d = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: state_d = IDLE;
      F_AH: if (xfer) begin
        addr_d[FONT_AW-1:8] = in_data[FONT_AW-9:0];
        state_d = F_AL;
      end
      F_AL: if (xfer) begin addr_d[7:0] = in_data; state_d = F_CNT; end
      F_CNT: if (xfer) begin
        cnt_d = in_data;
        if (in_data != 8'd0) begin
          fchg_d  = 1'b1;
          state_d = F_DATA;
        end else begin
          state_d = F_END;
        end
      end
      F_DATA: if (xfer) begin
        hi_d     = in_data[7:4];
        cnt_d    = cnt_q - 8'd1;
        fwdata_d = in_data[3:0];
        fwaddr_d = addr_q;
        fwen_d   = 1'b1;
        state_d  = F_WLO;
      end
      F_WLO: begin
        fwdata_d = hi_q;
        fwaddr_d = addr_q + FONT_AW'(1);
        fwen_d   = 1'b1;
        addr_d   = addr_q + FONT_AW'(2);
        state_d  = F_WHI;
      end
      F_WHI: begin
        if (cnt_q == 8'd0) begin
          fchg_d  = 1'b0;
          state_d = F_END;
        end else begin
          state_d = F_DATA;
        end
      end
      F_END:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Handshake and busy are registered from the next state so they line up with it.
    in_ready_d = (state_d == IDLE) || (state_d == P1) || (state_d == P2) ||
                 (state_d == P3) || (state_d == F_AH) || (state_d == F_AL) ||
                 (state_d == F_CNT) || (state_d == F_DATA);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_POS;
      b1_q       <= '0;
      xlo_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sprite_q   <= '0;
      vis_q      <= 1'b0;
      load_pos_q <= 1'b0;
      load_att_q <= 1'b0;
      bg_q       <= '0;
      bchg_q     <= 1'b0;
      fchg_q     <= 1'b0;
      fwaddr_q   <= '0;
      fwdata_q   <= '0;
      fwen_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      b1_q       <= b1_d;
      xlo_q      <= xlo_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sprite_q   <= sprite_d;
      vis_q      <= vis_d;
      load_pos_q <= load_pos_d;
      load_att_q <= load_att_d;
      bg_q       <= bg_d;
      bchg_q     <= bchg_d;
      fchg_q     <= fchg_d;
      fwaddr_q   <= fwaddr_d;
      fwdata_q   <= fwdata_d;
      fwen_q     <= fwen_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign x              = x_q;
  assign y              = y_q;
  assign sprite_sel     = sprite_q;
  assign visable        = vis_q;
  assign load_pos       = load_pos_q;
  assign load_att       = load_att_q;
  assign background_sel = bg_q;
  assign bchange_active = bchg_q;
  assign fchange_active = fchg_q;
  assign fwaddr         = fwaddr_q;
  assign fwdata         = fwdata_q;
  assign fwenable       = fwen_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_vga_cmd_decoder.sv
// Directed, table-driven bench for vga_cmd_decoder: SET_* vectors from a table,
// hand-written sequences for font bursts, bad opcodes and mid-packet reset.
module tb_vga_cmd_decoder;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [4:0]  sprite_sel;
  logic        visable, load_pos, load_att, bchange_active, fchange_active;
  logic [1:0]  background_sel;
  logic [10:0] fwaddr;
  logic [3:0]  fwdata;
  logic        fwenable, busy, err;

  vga_cmd_decoder #(.FONT_AW(11), .SPRITE_W(5)) dut (
    .clk_100(clk_100), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .y(y), .sprite_sel(sprite_sel), .visable(visable),
    .load_pos(load_pos), .load_att(load_att), .background_sel(background_sel),
    .bchange_active(bchange_active), .fchange_active(fchange_active),
    .fwaddr(fwaddr), .fwdata(fwdata), .fwenable(fwenable), .busy(busy), .err(err)
  );

  always #5 clk_100 = ~clk_100;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor: counts strobes and logs font writes, sampled mid-cycle.
  int n_pos = 0, n_att = 0, n_bg = 0, n_err = 0, n_fch = 0, n_bad = 0;
  logic [14:0] wr_q[$];

  always @(negedge clk_100) begin
    if (fwenable) wr_q.push_back({fwaddr, fwdata});
    if (fwenable && !fchange_active) n_bad++;
    if (fchange_active) n_fch++;
    if (load_pos) n_pos++;
    if (load_att) n_att++;
    if (bchange_active) n_bg++;
    if (err) n_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Presents one byte, waits (bounded) for acceptance; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk_100);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(negedge clk_100);
      waited++;
    end
    if (!in_ready) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk_100);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk_100);
    while (busy && waited < 200) begin
      @(negedge clk_100);
      waited++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    int          len;
    logic [31:0] bytes;
    logic [9:0]  ex;
    logic [8:0]  ey;
    logic [4:0]  espr;
    logic        evis;
    logic [1:0]  ebg;
    logic [2:0]  estb;   // {load_pos, load_att, bchange_active}
  } vec_t;

  vec_t        tbl[6];
  logic [14:0] exp_wr[4];
  int          base, s_pos, s_att, s_bg, s_err, s_fch, s_bad;

  initial begin
    tbl[0] = '{4, 32'h01A33412, 10'h134, 9'h112, 5'd3,  1'b0, 2'd0, 3'b100};
    tbl[1] = '{2, 32'h02850000, 10'h134, 9'h112, 5'd5,  1'b1, 2'd0, 3'b010};
    tbl[2] = '{2, 32'h03020000, 10'h134, 9'h112, 5'd5,  1'b1, 2'd2, 3'b001};
    tbl[3] = '{4, 32'h015FFF00, 10'h2FF, 9'h000, 5'd31, 1'b1, 2'd2, 3'b100};
    tbl[4] = '{2, 32'h021A0000, 10'h2FF, 9'h000, 5'd26, 1'b0, 2'd2, 3'b010};
    tbl[5] = '{2, 32'hF3030000, 10'h2FF, 9'h000, 5'd26, 1'b0, 2'd3, 3'b001};
    exp_wr[0] = {11'h7FE, 4'h5};
    exp_wr[1] = {11'h7FF, 4'hA};
    exp_wr[2] = {11'h000, 4'hC};
    exp_wr[3] = {11'h001, 4'h3};

    // Reset asserted, then released
    repeat (2) @(posedge clk_100);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outputs", {x, y, sprite_sel, visable, background_sel},  32'd0);
    @(negedge clk_100);
    rst = 1'b1;
    @(posedge clk_100);
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_busy", {31'd0, busy}, 32'd0);
    check("rel_strobes", {load_pos, load_att, bchange_active, fchange_active, fwenable, err}, 32'd0);

    // Table of SET_* commands, sent back-to-back
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].len; k++) send(tbl[i].bytes[31-8*k -: 8]);
      check($sformatf("v%0d_strobe", i), {29'd0, load_pos, load_att, bchange_active}, {29'd0, tbl[i].estb});
      check($sformatf("v%0d_ready_low", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("v%0d_x", i), {22'd0, x}, {22'd0, tbl[i].ex});
      check($sformatf("v%0d_y", i), {23'd0, y}, {23'd0, tbl[i].ey});
      check($sformatf("v%0d_spr_vis_bg", i), {24'd0, sprite_sel, visable, background_sel},
            {24'd0, tbl[i].espr, tbl[i].evis, tbl[i].ebg});
      @(posedge clk_100);
      #1;
      check($sformatf("v%0d_after", i), {28'd0, load_pos, load_att, bchange_active, busy}, 32'd0);
      check($sformatf("v%0d_ready_back", i), {31'd0, in_ready}, 32'd1);
    end

    // Font burst with input gaps, address wrapping 7FF -> 000
    base = wr_q.size(); s_fch = n_fch; s_bad = n_bad;
    send(8'h04); send(8'h07); send(8'hFE); send(8'h02);
    repeat (3) @(posedge clk_100);
    send(8'hA5);
    repeat (2) @(posedge clk_100);
    send(8'h3C);
    wait_idle();
    check("font_nwrites", wr_q.size() - base, 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < wr_q.size())
        check($sformatf("font_wr%0d", i), {17'd0, wr_q[base+i]}, {17'd0, exp_wr[i]});
    check("font_en_outside_burst", n_bad - s_bad, 32'd0);
    check("font_fch_span_ge6", {31'd0, (n_fch - s_fch) >= 6}, 32'd1);
    check("font_fch_end", {31'd0, fchange_active}, 32'd0);

    // Unknown opcode, then a normal command
    s_pos = n_pos; s_att = n_att; s_bg = n_bg; s_err = n_err;
    send(8'h0F);
    check("err_pulse", {30'd0, err, busy}, 32'b10);
    check("err_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk_100);
    #1;
    check("err_gone", {31'd0, err}, 32'd0);
    send(8'h03); send(8'h01);
    check("after_err_bg", {30'd0, bchange_active, background_sel == 2'd1}, 32'b11);
    wait_idle();
    check("err_count", n_err - s_err, 32'd1);
    check("err_no_pos_att", (n_pos - s_pos) + (n_att - s_att), 32'd0);
    check("err_bg_count", n_bg - s_bg, 32'd1);

    // Zero-length font burst
    base = wr_q.size(); s_fch = n_fch;
    send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    check("n0_fend", {29'd0, busy, in_ready, fchange_active}, 32'b100);
    wait_idle();
    check("n0_nwrites", wr_q.size() - base, 32'd0);
    check("n0_fch", n_fch - s_fch, 32'd0);

    // Reset in the middle of SET_POS
    send(8'h01); send(8'hA3);
    @(negedge clk_100);
    rst = 1'b0;
    #1;
    check("mid_rst_clear", {x, y, sprite_sel, visable, background_sel}, 32'd0);
    check("mid_rst_ready_busy", {30'd0, in_ready, busy}, 32'd0);
    @(negedge clk_100);
    rst = 1'b1;
    s_pos = n_pos; s_bg = n_bg;
    send(8'h03); send(8'h01);
    wait_idle();
    repeat (2) @(posedge clk_100);
    #1;
    check("mid_rst_no_pos", n_pos - s_pos, 32'd0);
    check("mid_rst_bg_once", n_bg - s_bg, 32'd1);
    check("mid_rst_state", {24'd0, sprite_sel, background_sel, 1'b0}, {24'd0, 5'd0, 2'd1, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
